// File: rtl/ctrl_input_pkg.sv
`timescale 1ns/1ps
// Shared types and default timing for the controller input port shift-register reader.
// Pure declarations: no logic, no latency, no flow control.
package ctrl_input_pkg;

    localparam int CTRL_BITS       = 16;
    localparam int DEF_HALF_CP     = 4;
    localparam int DEF_PL_CYCLES   = 2;
    localparam int DEF_REC_CYCLES  = 2;
    localparam int DEF_POLL_CYCLES = 1000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RECOVER,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// Two-flop synchroniser for a single asynchronous bit.
// Latency: 2 clocks; no backpressure.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ctrl_sreg_reader.sv
`timescale 1ns/1ps
// Polls two chained 74HC165D registers and presents the button word with a one-cycle valid strobe.
// Latency: PL_CYCLES+REC_CYCLES+2*HALF_CP*NUM_BITS+1 clocks from IDLE exit to valid; free-running, no backpressure.
// CTRL_SREG_DEBOUNCE_EN: publish only when two consecutive raw scans agree.
module ctrl_sreg_reader
    import ctrl_input_pkg::*;
#(
    parameter int NUM_BITS    = CTRL_BITS,
    parameter int HALF_CP     = DEF_HALF_CP,
    parameter int PL_CYCLES   = DEF_PL_CYCLES,
    parameter int REC_CYCLES  = DEF_REC_CYCLES,
    parameter int POLL_CYCLES = DEF_POLL_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sr_q7,
    output logic                sr_pl_n,
    output logic                sr_cp,
    output logic                sr_ce_n,
    output logic [NUM_BITS-1:0] buttons,
    output logic                valid
);

    localparam int PH_MAX = (HALF_CP > PL_CYCLES)
                          ? ((HALF_CP > REC_CYCLES) ? HALF_CP : REC_CYCLES)
                          : ((PL_CYCLES > REC_CYCLES) ? PL_CYCLES : REC_CYCLES);
    localparam int PH_W   = cnt_w(PH_MAX);
    localparam int POLL_W = cnt_w(POLL_CYCLES);
    localparam int BIT_W  = cnt_w(NUM_BITS);

    localparam logic [POLL_W-1:0] POLL_TC = POLL_W'(POLL_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_TC  = BIT_W'(NUM_BITS - 1);
    localparam logic [PH_W-1:0]   PL_TC   = PH_W'(PL_CYCLES - 1);
    localparam logic [PH_W-1:0]   REC_TC  = PH_W'(REC_CYCLES - 1);
    localparam logic [PH_W-1:0]   HALF_TC = PH_W'(HALF_CP - 1);

    state_t state_q, state_d;

    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic [NUM_BITS-1:0] buttons_q, buttons_d;
    logic                valid_q, valid_d;
    logic                pl_n_q, pl_n_d;
    logic                cp_q, cp_d;
    logic                ce_n_q, ce_n_d;
`ifdef CTRL_SREG_DEBOUNCE_EN
    logic [NUM_BITS-1:0] prev_q, prev_d;
`endif

    logic q7_sync;
    logic poll_exp;
    logic phase_last;
    logic last_bit;

    sync_2ff u_q7_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sr_q7),
        .q_o (q7_sync)
    );

    assign poll_exp = (poll_q == POLL_TC);
    assign last_bit = (bit_q == BIT_TC);

    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            LOAD:     phase_last = (phase_q == PL_TC);
            RECOVER:  phase_last = (phase_q == REC_TC);
            SHIFT_LO: phase_last = (phase_q == HALF_TC);
            SHIFT_HI: phase_last = (phase_q == HALF_TC);
            default:  phase_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (poll_exp && en) state_d = LOAD;
            LOAD:     if (phase_last)     state_d = RECOVER;
            RECOVER:  if (phase_last)     state_d = SHIFT_LO;
            SHIFT_LO: if (phase_last)     state_d = SHIFT_HI;
            SHIFT_HI: if (phase_last)     state_d = last_bit ? DONE : SHIFT_LO;
            DONE:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Pin levels decode the upcoming state so the chain sees glitch-free registered strobes.
    always_comb begin
        pl_n_d = 1'b1;
        cp_d   = 1'b0;
        ce_n_d = 1'b1;
        case (state_d)
            LOAD:     pl_n_d = 1'b0;
            RECOVER:  ce_n_d = 1'b0;
            SHIFT_LO: ce_n_d = 1'b0;
            SHIFT_HI: begin
                ce_n_d = 1'b0;
                cp_d   = 1'b1;
            end
            default: begin
                pl_n_d = 1'b1;
                cp_d   = 1'b0;
                ce_n_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        poll_d    = poll_q;
        phase_d   = (state_q == IDLE || state_d != state_q) ? '0 : phase_q + 1'b1;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
`ifdef CTRL_SREG_DEBOUNCE_EN
        prev_d    = prev_q;
`endif
        case (state_q)
            IDLE:     if (!poll_exp) poll_d = poll_q + 1'b1;
            RECOVER:  bit_d = '0;
            SHIFT_LO: if (phase_last) shreg_d = {shreg_q[NUM_BITS-2:0], q7_sync};
            SHIFT_HI: if (phase_last) bit_d = bit_q + 1'b1;
            DONE: begin
                poll_d = '0;
`ifdef CTRL_SREG_DEBOUNCE_EN
                if (shreg_q == prev_q) begin
                    buttons_d = shreg_q;
                    valid_d   = 1'b1;
                end
                prev_d = shreg_q;
`else
                buttons_d = shreg_q;
                valid_d   = 1'b1;
`endif
            end
            default: poll_d = poll_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_q    <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            pl_n_q    <= 1'b1;
            cp_q      <= 1'b0;
            ce_n_q    <= 1'b1;
`ifdef CTRL_SREG_DEBOUNCE_EN
            prev_q    <= '0;
`endif
        end else begin
            poll_q    <= poll_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            pl_n_q    <= pl_n_d;
            cp_q      <= cp_d;
            ce_n_q    <= ce_n_d;
`ifdef CTRL_SREG_DEBOUNCE_EN
            prev_q    <= prev_d;
`endif
        end
    end

    assign sr_pl_n = pl_n_q;
    assign sr_cp   = cp_q;
    assign sr_ce_n = ce_n_q;
    assign buttons = buttons_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_ctrl_sreg_reader.sv
`timescale 1ns/1ps
// Bench for ctrl_sreg_reader: two behavioural 74HC165D models, a cycle-level scan-schedule model and a pin timing checker.
module tb_ctrl_sreg_reader;

    localparam int NB        = 16;
    localparam int H         = 4;
    localparam int PL        = 2;
    localparam int REC       = 2;
    localparam int POLL      = 1000;
    localparam int SHIFT_LEN = 2 * H * NB;
    localparam int SCAN_LEN  = PL + REC + SHIFT_LEN + 1;
`ifdef CTRL_SREG_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          sr_q7;
    logic          sr_pl_n, sr_cp, sr_ce_n, valid;
    logic [NB-1:0] buttons;

    logic [7:0] dn1 = 8'h00, dn2 = 8'h00;
    logic [7:0] chip1 = 8'h00, chip2 = 8'h00;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, cyc_plf = 0, pl_falls = 0, vld_cnt = 0;

    ctrl_sreg_reader #(
        .NUM_BITS(NB), .HALF_CP(H), .PL_CYCLES(PL), .REC_CYCLES(REC), .POLL_CYCLES(POLL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sr_q7(sr_q7),
        .sr_pl_n(sr_pl_n), .sr_cp(sr_cp), .sr_ce_n(sr_ce_n),
        .buttons(buttons), .valid(valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 'h%0h (%0d), expected 'h%0h (%0d)", name, act, act, exp, exp);
    endtask

    function automatic longint ps(input realtime t);
        return longint'(t * 1000.0);
    endfunction

    // Chain: chip1 DS=0 feeds chip2, chip2 Q7 is the serial output.
    always @(negedge sr_pl_n or posedge sr_cp) begin
        if (!sr_pl_n) begin
            chip1 = dn1;
            chip2 = dn2;
        end else if (!sr_ce_n) begin
            chip2 = {chip2[6:0], chip1[7]};
            chip1 = {chip1[6:0], 1'b0};
        end
    end
    assign sr_q7 = chip2[7];

    // Scan-schedule model: idle poll time, then a fixed-length scan that publishes the loaded word.
    bit            m_ok = 0, m_scan = 0, m_vld = 0, m_done = 0;
    int            m_idle = 0, m_sc = 0;
    logic [NB-1:0] m_btn = '0, m_prev = '0, m_word = '0;

    always @(posedge clk) begin
        m_done = 0;
        if (rst) begin
            m_ok = 1; m_scan = 0; m_vld = 0; m_idle = 0; m_sc = 0;
            m_btn = '0; m_prev = '0;
        end else if (m_scan) begin
            m_sc++;
            m_vld = 0;
            if (m_sc == SCAN_LEN) begin
                m_scan = 0; m_idle = 0; m_done = 1;
                if (!DEB || m_word == m_prev) begin
                    m_btn = m_word;
                    m_vld = 1;
                end
                m_prev = m_word;
            end
        end else begin
            m_vld = 0;
            if (m_idle >= POLL - 1 && en) begin
                m_scan = 1; m_sc = 0; m_word = {dn2, dn1};
            end else if (m_idle < POLL - 1) begin
                m_idle++;
            end
        end
    end

    always @(negedge clk) begin
        int k;
        bit e_pl, e_cp, e_ce;
        if (valid) vld_cnt++;
        if (m_ok) begin
            k    = m_sc - PL - REC;
            e_pl = !(m_scan && m_sc < PL);
            e_ce = !(m_scan && m_sc >= PL && m_sc < PL + REC + SHIFT_LEN);
            e_cp = m_scan && k >= 0 && k < SHIFT_LEN && ((k / H) % 2 == 1);
            chk(buttons == m_btn && valid == m_vld, "out_word", {valid, buttons}, {m_vld, m_btn});
            chk({sr_pl_n, sr_cp, sr_ce_n} == {e_pl, e_cp, e_ce}, "pins",
                {sr_pl_n, sr_cp, sr_ce_n}, {e_pl, e_cp, e_ce});
        end
    end

    realtime t_plf = -1.0, t_plr = -1.0, t_cpr = -1.0, t_cpf = -1.0;
    bit      cp_first = 0;

    always @(negedge sr_pl_n) begin
        t_plf   = $realtime;
        cyc_plf = cyc;
        pl_falls++;
    end

    always @(posedge sr_pl_n) begin
        if (t_plf >= 0.0) chk(($realtime - t_plf) >= 16.0, "pl_low_width", ps($realtime - t_plf), 16000);
        t_plr    = $realtime;
        cp_first = 1;
    end

    always @(posedge sr_cp) begin
        chk(sr_pl_n == 1'b1, "cp_rise_during_pl", sr_pl_n, 1);
        chk(sr_ce_n == 1'b0, "ce_n_at_cp_rise", sr_ce_n, 0);
        if (cp_first) begin
            chk(($realtime - t_plr) >= 20.0, "pl_to_first_cp", ps($realtime - t_plr), 20000);
            cp_first = 0;
        end else if (t_cpf >= 0.0) begin
            chk(($realtime - t_cpf) >= 16.0, "cp_low_width", ps($realtime - t_cpf), 16000);
        end
        t_cpr = $realtime;
    end

    always @(negedge sr_cp) begin
        chk(sr_pl_n == 1'b1, "cp_fall_during_pl", sr_pl_n, 1);
        if (t_cpr >= 0.0) chk(($realtime - t_cpr) >= 16.0, "cp_high_width", ps($realtime - t_cpr), 16000);
        t_cpf = $realtime;
    end

    task automatic wait_done(input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (m_done) begin
                hit = 1;
                break;
            end
        end
        if (!hit) chk(1'b0, {"timeout_", tag}, 0, 1);
    endtask

    task automatic set_word(input logic [15:0] w);
        @(negedge clk);
        {dn2, dn1} = w;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [15:0] pats [3];
        int base;
        bit hit;
        pats[0] = 16'h5555; pats[1] = 16'hF0F0; pats[2] = 16'h0F0F;

        {dn2, dn1} = 16'hAAAA;
        repeat (3) @(posedge clk);
        #1;
        chk({sr_pl_n, sr_cp, sr_ce_n, valid} == 4'b1010, "reset_pins", {sr_pl_n, sr_cp, sr_ce_n, valid}, 4'b1010);
        chk(buttons == 16'h0000, "reset_buttons", buttons, 0);

        @(negedge clk) rst = 0;
        repeat (1200) @(posedge clk);
        #1;
        chk(pl_falls == 0, "no_load_en0", pl_falls, 0);
        chk(vld_cnt == 0, "no_valid_en0", vld_cnt, 0);

        @(negedge clk) en = 1;
        @(posedge clk);
        #1;
        chk(sr_pl_n == 1'b0, "start_next_cycle", sr_pl_n, 0);
        repeat (10) @(negedge clk);
        en = 0;
        wait_done("first");
`ifndef CTRL_SREG_DEBOUNCE_EN
        chk(valid == 1'b1, "first_valid", valid, 1);
        chk(buttons == 16'hAAAA, "first_word", buttons, 16'hAAAA);
        chk(m_btn == 16'hAAAA, "model_first_word", m_btn, 16'hAAAA);
        chk(cyc - cyc_plf == 133, "scan_latency", cyc - cyc_plf, 133);
`endif
        base = pl_falls;
        repeat (1300) @(posedge clk);
        #1;
        chk(pl_falls == base, "no_scan_after_en_drop", pl_falls, base);

        for (int p = 0; p < 3; p++) begin
            set_word(pats[p]);
            en = 1;
            wait_done("pattern");
`ifndef CTRL_SREG_DEBOUNCE_EN
            chk(buttons == pats[p], "pattern_word", buttons, pats[p]);
            chk(valid == 1'b1, "pattern_valid", valid, 1);
`endif
        end

        hit = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (m_scan && m_sc == 49) begin
                hit = 1;
                break;
            end
        end
        chk(hit, "reach_bit5_shift_hi", hit, 1);
        rst = 1;
        @(posedge clk);
        #1;
        chk({sr_pl_n, sr_cp, sr_ce_n, valid} == 4'b1010, "midscan_reset_pins", {sr_pl_n, sr_cp, sr_ce_n, valid}, 4'b1010);
        chk(buttons == 16'h0000, "midscan_reset_buttons", buttons, 0);
        @(negedge clk);
        rst = 0;
        {dn2, dn1} = 16'hC3A5;
        wait_done("after_reset");
`ifndef CTRL_SREG_DEBOUNCE_EN
        chk(buttons == 16'hC3A5, "after_reset_word", buttons, 16'hC3A5);
`endif

`ifdef CTRL_SREG_DEBOUNCE_EN
        set_word(16'h1234); wait_done("deb1");
        chk(valid == 1'b0, "deb_first_no_valid", valid, 0);
        set_word(16'h5678); wait_done("deb2");
        chk(buttons != 16'h5678, "deb_second_not_yet", buttons, 16'h5678);
        set_word(16'h5678); wait_done("deb3");
        chk(buttons == 16'h5678 && valid == 1'b1, "deb_third_word", {valid, buttons}, {1'b1, 16'h5678});
        set_word(16'hDEAD); wait_done("deb_glitch");
        chk(buttons == 16'h5678 && valid == 1'b0, "deb_glitch_hidden", {valid, buttons}, {1'b0, 16'h5678});
        set_word(16'h5678); wait_done("deb_back");
        chk(buttons == 16'h5678, "deb_back_word", buttons, 16'h5678);
`endif

        w = 16'h0000;
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 0) w = 16'($urandom);
            set_word(w);
            if ($urandom_range(0, 3) == 0) begin
                en = 0;
                repeat ($urandom_range(50, 1500)) @(negedge clk);
                en = 1;
            end
            wait_done("random");
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
